// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS64 subset core: opcodes, functs, ALU ops and
// the memwrite bus encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_DADDI = 6'h18;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LD    = 6'h37;
  localparam logic [5:0] OP_SD    = 6'h3f;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_DADD = 6'h2c;
  localparam logic [5:0] FN_DSUB = 6'h2e;

  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_WORD  = 2'b01;
  localparam logic [1:0] MW_DWORD = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD32,
    ALU_SUB32,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ADD64,
    ALU_SUB64
  } alu_op_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/mips64_if.sv
// Fetch/data bus of the MIPS64 core as seen by the system around it.
interface mips64_if;
  logic [63:0] writedata;
  logic [63:0] dataadr;
  logic [1:0]  memwrite;
  logic [31:0] instradr;
  logic [31:0] instr;
  logic [63:0] readdata;
  logic [7:0]  pclow;

  modport master (
    output writedata, dataadr, memwrite, instradr, instr, readdata, pclow
  );

  modport slave (
    input writedata, dataadr, memwrite, instradr, instr, readdata, pclow
  );
endinterface

// File: rtl/mips_regfile.sv
// 32 x 64-bit register file, async clear; r0 is never written so it reads 0.
// The third (debug) read port exists only with MIPS_DEBUG_PORT_EN.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [63:0] rd1,
  output logic [63:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd
`ifdef MIPS_DEBUG_PORT_EN
  ,
  input  logic [4:0]  ra3,
  output logic [63:0] rd3
`endif
);

  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
`ifdef MIPS_DEBUG_PORT_EN
  assign rd3 = regs_q[ra3];
`endif

endmodule

// File: rtl/mips64_top.sv
// Single-cycle MIPS64 subset CPU with a unified word-addressed memory.
// Define MIPS_DEBUG_PORT_EN to drive the check/memdata debug read ports.
module mips64_top
  import mips_pkg::*;
#(
  parameter              MEMFILE   = "memfile.dat",
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  mips64_if.master    bus,
  input  logic [4:0]  checka,
  output logic [63:0] check,
  input  logic [7:0]  addr,
  output logic [31:0] memdata
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic [63:0] imm_sext, srca, srcb, rt_val, alu_res, wb_data, ld_data, lw_data;
  logic        reg_we, use_imm, is_lw, is_ld, br_eq, br_ne, jump, taken;
  logic [1:0]  mw;
  alu_op_e     alu_op;
  logic [AW-1:0] d_idx, d_idx1;

  assign instr    = mem_q[pc_q[AW+1:2]];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{48{instr[15]}}, instr[15:0]};

  always_comb begin
    reg_we  = 1'b0;
    wa      = rt;
    alu_op  = ALU_ADD64;
    use_imm = 1'b1;
    is_lw   = 1'b0;
    is_ld   = 1'b0;
    mw      = MW_NONE;
    br_eq   = 1'b0;
    br_ne   = 1'b0;
    jump    = 1'b0;
    case (op)
      OP_RTYPE: begin
        use_imm = 1'b0;
        wa      = rd;
        reg_we  = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD32;
          FN_SUB:  alu_op = ALU_SUB32;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_DADD: alu_op = ALU_ADD64;
          FN_DSUB: alu_op = ALU_SUB64;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI:  begin reg_we = 1'b1; alu_op = ALU_ADD32; end
      OP_DADDI: reg_we = 1'b1;
      OP_LW:    begin reg_we = 1'b1; is_lw = 1'b1; end
      OP_LD:    begin reg_we = 1'b1; is_ld = 1'b1; end
      OP_SW:    mw = MW_WORD;
      OP_SD:    mw = MW_DWORD;
      OP_BEQ:   begin use_imm = 1'b0; br_eq = 1'b1; end
      OP_BNE:   begin use_imm = 1'b0; br_ne = 1'b1; end
      OP_J:     jump = 1'b1;
      default:  ;
    endcase
  end

  mips_regfile u_rf (
    .clk (clk),
    .rst (reset),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (srca),
    .rd2 (rt_val),
    .we  (reg_we),
    .wa  (wa),
    .wd  (wb_data)
`ifdef MIPS_DEBUG_PORT_EN
    ,
    .ra3 (checka),
    .rd3 (check)
`endif
  );

  assign srcb = use_imm ? imm_sext : rt_val;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD32: alu_res = sext32(srca[31:0] + srcb[31:0]);
      ALU_SUB32: alu_res = sext32(srca[31:0] - srcb[31:0]);
      ALU_AND:   alu_res = srca & srcb;
      ALU_OR:    alu_res = srca | srcb;
      ALU_SLT:   alu_res = {63'd0, $signed(srca) < $signed(srcb)};
      ALU_ADD64: alu_res = srca + srcb;
      ALU_SUB64: alu_res = srca - srcb;
      default:   alu_res = '0;
    endcase
  end

  // Doubleword accesses use word i (low) and i+1 (high), wrapping at the top.
  assign d_idx   = alu_res[AW+1:2];
  assign d_idx1  = d_idx + 1'b1;
  assign ld_data = {mem_q[d_idx1], mem_q[d_idx]};
  assign lw_data = sext32(mem_q[d_idx]);
  assign wb_data = is_lw ? lw_data : (is_ld ? ld_data : alu_res);

  assign pc_plus4 = pc_q + 32'd4;
  assign taken    = (br_eq && (srca == rt_val)) || (br_ne && (srca != rt_val));

  always_comb begin
    pc_d = pc_plus4;
    if (jump)       pc_d = {pc_q[31:28], instr[25:0], 2'b00};
    else if (taken) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  // bus.memwrite is already forced to none while reset is high.
  always_ff @(posedge clk) begin
    if (bus.memwrite != MW_NONE)  mem_q[d_idx]  <= rt_val[31:0];
    if (bus.memwrite == MW_DWORD) mem_q[d_idx1] <= rt_val[63:32];
  end

  assign bus.instradr  = pc_q;
  assign bus.instr     = instr;
  assign bus.pclow     = pc_q[9:2];
  assign bus.dataadr   = alu_res;
  assign bus.memwrite  = reset ? MW_NONE : mw;
  assign bus.writedata = (mw != MW_NONE) ? rt_val : '0;
  assign bus.readdata  = is_lw ? lw_data : ld_data;

`ifdef MIPS_DEBUG_PORT_EN
  assign memdata = mem_q[AW'(addr)];
`else
  logic unused_dbg;
  assign check      = '0;
  assign memdata    = '0;
  assign unused_dbg = ^{checka, addr};
`endif

endmodule

// File: tb/tb_mips64_top.sv
// Directed bench for mips64_top: reset, three store-terminated programs,
// a per-instruction vector table, and a branch-loop / mid-run reset sequence.
module tb_mips64_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  checka = '0;
  logic [63:0] check;
  logic [7:0]  addr = '0;
  logic [31:0] memdata;

  mips64_if bus ();

  mips64_top #(.MEMFILE(""), .MEM_WORDS(256)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .checka  (checka),
    .check   (check),
    .addr    (addr),
    .memdata (memdata)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] prog [$];

  typedef struct {
    string       name;
    logic [31:0] ins;
    bit          is_mem;
    logic [7:0]  idx;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [$];

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      dut.mem_q[i] <= (i < prog.size()) ? prog[i] : 32'h0;
    #1;
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b1;
    load_prog();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [63:0] v);
`ifdef MIPS_DEBUG_PORT_EN
    checka = r;
    #1;
    v = check;
`else
    v = dut.u_rf.regs_q[r];
`endif
  endtask

  task automatic read_mem(input logic [7:0] i, output logic [63:0] v);
`ifdef MIPS_DEBUG_PORT_EN
    addr = i;
    #1;
    v = {32'h0, memdata};
`else
    v = {32'h0, dut.mem_q[i]};
`endif
  endtask

  task automatic wait_store(input string name, input logic [63:0] adr,
                            input logic [1:0] mw, input logic [63:0] wd);
    bit found = 1'b0;
    for (int c = 0; c < 48 && !found; c++) begin
      @(negedge clk);
      if (bus.memwrite != 2'b00 && bus.dataadr == adr) found = 1'b1;
    end
    chk({name, "_seen"}, 64'(found), 64'd1);
    if (found) begin
      chk({name, "_memwrite"}, 64'(bus.memwrite), 64'(mw));
      chk({name, "_writedata"}, bus.writedata, wd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;

    // Reset: a store at word 0 must stay invisible while reset is high.
    prog.delete();
    prog.push_back(32'hAC00_0000);
    load_prog();
    chk("rst_instradr", 64'(bus.instradr), 64'd0);
    chk("rst_pclow", 64'(bus.pclow), 64'd0);
    chk("rst_memwrite", 64'(bus.memwrite), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'hAC00_0000);
    #21 reset = 1'b0;
    #1;
    chk("first_fetch_instradr", 64'(bus.instradr), 64'd0);
    chk("first_fetch_memwrite", 64'(bus.memwrite), 64'd1);
    chk("first_fetch_dataadr", bus.dataadr, 64'd0);
    @(posedge clk); #1;
    chk("first_fetch_next_pc", 64'(bus.instradr), 64'd4);

    // Standard program.
    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 2, 16'd5));
    prog.push_back(enc_i(6'h08, 0, 3, 16'd12));
    prog.push_back(enc_i(6'h08, 3, 7, 16'hFFF7));
    prog.push_back(enc_r(6'h25, 7, 2, 4));
    prog.push_back(enc_r(6'h24, 3, 4, 5));
    prog.push_back(enc_r(6'h20, 5, 4, 5));
    prog.push_back(enc_i(6'h04, 5, 7, 16'd10));
    prog.push_back(enc_r(6'h2a, 3, 4, 4));
    prog.push_back(enc_i(6'h04, 4, 0, 16'd1));
    prog.push_back(enc_i(6'h08, 0, 5, 16'd0));
    prog.push_back(enc_r(6'h2a, 7, 2, 4));
    prog.push_back(enc_r(6'h20, 4, 5, 7));
    prog.push_back(enc_r(6'h22, 7, 2, 7));
    prog.push_back(enc_i(6'h2b, 3, 7, 16'd68));
    prog.push_back(enc_i(6'h23, 0, 2, 16'd80));
    prog.push_back({6'h02, 26'h11});
    prog.push_back(enc_i(6'h08, 0, 2, 16'd1));
    prog.push_back(enc_i(6'h2b, 0, 2, 16'd84));
    restart();
    wait_store("std_sw80", 64'd80, 2'b01, 64'd7);
    wait_store("std_sw84", 64'd84, 2'b01, 64'd7);
    @(posedge clk); #1;
    read_mem(8'd21, v); chk("std_mem21", v, 64'd7);

    // Power-of-two accumulation loop ending in sd.
    prog.delete();
    prog.push_back(enc_i(6'h18, 0, 1, 16'd1));
    prog.push_back(enc_i(6'h18, 0, 2, 16'd3));
    prog.push_back(enc_i(6'h18, 0, 3, 16'd0));
    prog.push_back(enc_r(6'h2c, 3, 1, 3));
    prog.push_back(enc_r(6'h2c, 1, 1, 1));
    prog.push_back(enc_i(6'h18, 2, 2, 16'hFFFF));
    prog.push_back(enc_i(6'h05, 2, 0, 16'hFFFC));
    prog.push_back(enc_i(6'h3f, 0, 3, 16'd128));
    restart();
    wait_store("p2_sd", 64'd128, 2'b11, 64'd7);
    @(posedge clk); #1;
    read_mem(8'd32, v); chk("p2_mem32", v, 64'd7);
    read_mem(8'd33, v); chk("p2_mem33", v, 64'd0);

    // Load/store program.
    prog.delete();
    prog.push_back(enc_i(6'h18, 0, 1, 16'hFFFE));
    prog.push_back(enc_i(6'h3f, 0, 1, 16'd96));
    prog.push_back(enc_i(6'h37, 0, 2, 16'd96));
    prog.push_back(enc_i(6'h23, 0, 3, 16'd96));
    prog.push_back(enc_i(6'h23, 0, 4, 16'd100));
    prog.push_back(enc_r(6'h2a, 3, 4, 5));
    prog.push_back(enc_i(6'h2b, 0, 5, 16'd80));
    prog.push_back(enc_i(6'h3f, 0, 2, 16'd104));
    restart();
    wait_store("ls_sw", 64'd80, 2'b01, 64'd1);
    wait_store("ls_sd", 64'd104, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE);

    // Per-instruction vector table; data words live at indices 40/41.
    vecs.delete();
    vecs.push_back('{"daddi_m1",  enc_i(6'h18, 0, 1, 16'hFFFF), 1'b0, 8'd1,  64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"addi_r0",   enc_i(6'h08, 0, 0, 16'd5),    1'b0, 8'd0,  64'h0});
    vecs.push_back('{"addi_max",  enc_i(6'h08, 0, 2, 16'h7FFF), 1'b0, 8'd2,  64'h7FFF});
    vecs.push_back('{"add",       enc_r(6'h20, 2, 2, 3),        1'b0, 8'd3,  64'hFFFE});
    vecs.push_back('{"addi_min",  enc_i(6'h08, 0, 4, 16'h8000), 1'b0, 8'd4,  64'hFFFF_FFFF_FFFF_8000});
    vecs.push_back('{"ld",        enc_i(6'h37, 0, 5, 16'd160),  1'b0, 8'd5,  64'h0000_0001_0000_0002});
    vecs.push_back('{"add_trunc", enc_r(6'h20, 5, 5, 6),        1'b0, 8'd6,  64'h4});
    vecs.push_back('{"dadd",      enc_r(6'h2c, 5, 5, 7),        1'b0, 8'd7,  64'h0000_0002_0000_0004});
    vecs.push_back('{"sub",       enc_r(6'h22, 0, 5, 8),        1'b0, 8'd8,  64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{"dsub",      enc_r(6'h2e, 0, 5, 9),        1'b0, 8'd9,  64'hFFFF_FFFE_FFFF_FFFE});
    vecs.push_back('{"and",       enc_r(6'h24, 1, 5, 10),       1'b0, 8'd10, 64'h0000_0001_0000_0002});
    vecs.push_back('{"or",        enc_r(6'h25, 5, 4, 11),       1'b0, 8'd11, 64'hFFFF_FFFF_FFFF_8002});
    vecs.push_back('{"slt_true",  enc_r(6'h2a, 4, 5, 12),       1'b0, 8'd12, 64'h1});
    vecs.push_back('{"slt_false", enc_r(6'h2a, 5, 4, 13),       1'b0, 8'd13, 64'h0});
    vecs.push_back('{"lw",        enc_i(6'h23, 0, 14, 16'd164), 1'b0, 8'd14, 64'h1});
    vecs.push_back('{"sd_lo",     enc_i(6'h3f, 0, 5, 16'd8),    1'b1, 8'd2,  64'h2});
    vecs.push_back('{"bad_op_hi", {6'h10, 26'h0},               1'b1, 8'd3,  64'h1});
    vecs.push_back('{"bad_funct", enc_r(6'h21, 1, 1, 1),        1'b0, 8'd1,  64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"add_wrap",  enc_r(6'h20, 1, 1, 15),       1'b0, 8'd15, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{"add_low32", enc_r(6'h20, 7, 7, 16),       1'b0, 8'd16, 64'h8});
    prog.delete();
    for (int i = 0; i < 40; i++) prog.push_back((i < vecs.size()) ? vecs[i].ins : 32'h0);
    prog.push_back(32'h0000_0002);
    prog.push_back(32'h0000_0001);
    restart();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      chk({vecs[i].name, "_pc"}, 64'(bus.instradr), 64'(4 * (i + 1)));
      if (vecs[i].is_mem) read_mem(vecs[i].idx, v);
      else                read_reg(vecs[i].idx[4:0], v);
      chk(vecs[i].name, v, vecs[i].exp);
    end

    // Branch-to-self loop, then reset in the middle of it.
    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 1, 16'd9));
    prog.push_back(enc_i(6'h04, 0, 0, 16'hFFFF));
    restart();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("beq_self_pc", 64'(bus.instradr), 64'd4);
    end
    chk("beq_self_pclow", 64'(bus.pclow), 64'd1);
    read_reg(5'd1, v); chk("loop_r1", v, 64'd9);
`ifndef MIPS_DEBUG_PORT_EN
    checka = 5'd1; addr = 8'd1; #1;
    chk("nodbg_check_zero", check, 64'd0);
    chk("nodbg_memdata_zero", 64'(memdata), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_pc", 64'(bus.instradr), 64'd0);
    chk("midrst_memwrite", 64'(bus.memwrite), 64'd0);
    read_reg(5'd1, v); chk("midrst_r1", v, 64'd0);
    @(posedge clk); #1;
    chk("midrst_pc_held", 64'(bus.instradr), 64'd0);
    read_mem(8'd1, v); chk("midrst_mem_kept", v, 64'(enc_i(6'h04, 0, 0, 16'hFFFF)));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_pc", 64'(bus.instradr), 64'd4);
    read_reg(5'd1, v); chk("after_rst_r1", v, 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
